poly_mult_array_ctrl: RTL

Sequencer for an M-column systolic polynomial-multiplier array built from PE cells.
- Loads the M coefficients of operand B into the array's vertical (stationary) inputs.
- Streams the M coefficients of operand A, then zero padding, into the horizontal input.
- Steps the array and tags the 2M-1 product coefficients on the diagonal output with an index and valid/ready handshake.
- Sits between the operand coefficient RAMs, the PE array, and the result sink.

---
 rtl/poly_mult_array_ctrl_pkg.sv | 37 +++
 rtl/poly_mult_array_ctrl_if.sv | 49 ++++
 rtl/poly_mult_array_ctrl_step_counter.sv | 33 +++
 rtl/poly_mult_array_ctrl.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/poly_mult_array_ctrl_pkg.sv
// Shared definitions for the systolic polynomial-multiplier sequencer:
// FSM state encoding, a constant clog2 helper and derived width helpers.
package poly_mult_pkg;

  // FSM state encoding
  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_LOAD_B = 3'd1;
  localparam logic [2:0] ST_PRIME  = 3'd2;
  localparam logic [2:0] ST_RUN    = 3'd3;
  localparam logic [2:0] ST_DONE   = 3'd4;

  // Ceiling log2, never less than 1 so that every derived bus has a bit
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

  // Coefficient index width
  function automatic int idxw(input int m);
    return clog2(m);
  endfunction

  // Product coefficient index width (2M-1 coefficients)
  function automatic int resw(input int m);
    return clog2(2 * m - 1);
  endfunction

  // Step counter width: must hold 0 .. 2M-2+LAT
  function automatic int stepw(input int m, input int lat);
    return clog2(2 * m - 1 + lat);
  endfunction

endpackage

// File: rtl/poly_mult_array_ctrl_if.sv
// Bundle of sequencer signals toward the coefficient RAMs, the PE array and
// the result sink. The controller uses the master modport; the environment
// (RAMs, array, sink or a bench) uses the slave modport.
//
// Result handshake: the diag output holds coefficient res_idx whenever
// res_valid is high; it transfers on a rising clk edge where res_valid and
// res_ready are both high. While res_valid=1 and res_ready=0, res_valid,
// res_idx and the array contents stay stable until the sink accepts.
interface poly_mult_array_ctrl_if #(
  parameter int M   = 4,
  parameter int LAT = 4
);
  import poly_mult_pkg::*;

  localparam int IDXW = idxw(M);
  localparam int RESW = resw(M);

  logic            start;
  logic            busy;
  logic            done;
  logic            b_rd_en;
  logic [IDXW-1:0] b_rd_addr;
  logic            vert_load;
  logic [IDXW-1:0] vert_sel;
  logic            a_rd_en;
  logic [IDXW-1:0] a_rd_addr;
  logic            arr_clr;
  logic            array_en;
  logic            horz_zero;
  logic            res_valid;
  logic [RESW-1:0] res_idx;
  logic            res_ready;
  logic [2:0]      dbg_state;

  modport master (
    input  start, res_ready,
    output busy, done, b_rd_en, b_rd_addr, vert_load, vert_sel,
           a_rd_en, a_rd_addr, arr_clr, array_en, horz_zero,
           res_valid, res_idx, dbg_state
  );

  modport slave (
    output start, res_ready,
    input  busy, done, b_rd_en, b_rd_addr, vert_load, vert_sel,
           a_rd_en, a_rd_addr, arr_clr, array_en, horz_zero,
           res_valid, res_idx, dbg_state
  );

endinterface

// File: rtl/poly_mult_array_ctrl_step_counter.sv
// Up-counter with synchronous clear (priority over enable) and a flag that
// is high while the count equals the supplied terminal value.
module poly_mult_step_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr_i,
  input  logic         en_i,
  input  logic [W-1:0] last_i,
  output logic [W-1:0] cnt_o,
  output logic         tc_o
);

  logic [W-1:0] cnt_q, cnt_d;

  // Next count: clear wins, otherwise increment when enabled
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)     cnt_d = '0;
    else if (en_i) cnt_d = cnt_q + 1'b1;
  end

  // Count register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;
  assign tc_o  = (cnt_q == last_i);

endmodule

// File: rtl/poly_mult_array_ctrl.sv
// Sequencer for an M-column systolic polynomial multiplier. Loads operand B
// into the stationary column registers, streams operand A followed by zero
// padding into the horizontal input, and tags the 2M-1 product coefficients
// leaving the diagonal output. All outputs decode from registered state so
// that an asynchronous reset clears them immediately.
module poly_mult_array_ctrl
  import poly_mult_pkg::*;
#(
  parameter int N   = 4,
  parameter int M   = 4,
  parameter int LAT = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  poly_mult_array_ctrl_if.master bus
);

  localparam int IDXW  = idxw(M);
  localparam int RESW  = resw(M);
  localparam int STEPW = stepw(M, LAT);

  localparam logic [STEPW-1:0] K_LAST = STEPW'(M - 1);
  localparam logic [STEPW-1:0] S_LAST = STEPW'(2 * M - 2 + LAT);
  localparam logic [STEPW-1:0] M_S    = STEPW'(M);
  localparam logic [STEPW-1:0] LAT_S  = STEPW'(LAT);
  localparam logic [STEPW:0]   M_S1   = (STEPW + 1)'(M);

  // The last A read is issued before the first result appears only when
  // LAT >= M, which is what lets a stall freeze the array without losing
  // an in-flight RAM read.
  if (LAT < M) begin : g_bad_lat
    $error("poly_mult_array_ctrl: LAT must be >= M");
  end
  if (N < 1) begin : g_bad_n
    $error("poly_mult_array_ctrl: N must be >= 1");
  end

  logic [2:0]       state_q, state_d;
  logic [STEPW-1:0] k_cnt, s_cnt;
  logic [STEPW:0]   s_plus1;
  logic             k_tc, s_tc;
  logic             k_clr, k_en, s_clr, s_en;
  logic             in_run, stall, step;

  // Counter control: k walks LOAD_B, s walks RUN and freezes on a stall
  always_comb begin
    in_run  = (state_q == ST_RUN);
    stall   = in_run && (s_cnt >= LAT_S) && !bus.res_ready;
    step    = in_run && !stall;
    k_en    = (state_q == ST_LOAD_B);
    k_clr   = !k_en || k_tc;
    s_en    = step;
    s_clr   = !in_run || (step && s_tc);
    s_plus1 = {1'b0, s_cnt} + 1'b1;
  end

  poly_mult_step_counter #(.W(STEPW)) u_k_cnt (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (k_clr),
    .en_i   (k_en),
    .last_i (K_LAST),
    .cnt_o  (k_cnt),
    .tc_o   (k_tc)
  );

  poly_mult_step_counter #(.W(STEPW)) u_s_cnt (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (s_clr),
    .en_i   (s_en),
    .last_i (S_LAST),
    .cnt_o  (s_cnt),
    .tc_o   (s_tc)
  );

  // Next-state logic; start is only looked at in IDLE
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (bus.start) state_d = ST_LOAD_B;
      ST_LOAD_B: if (k_tc) state_d = ST_PRIME;
      ST_PRIME:  state_d = ST_RUN;
      ST_RUN:    if (step && s_tc) state_d = ST_DONE;
      ST_DONE:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Output decode; B RAM data arrives one cycle after its read, so each
  // column latch trails its read by one cycle and the last lands in PRIME
  always_comb begin
    bus.busy      = 1'b0;
    bus.done      = 1'b0;
    bus.b_rd_en   = 1'b0;
    bus.b_rd_addr = '0;
    bus.vert_load = 1'b0;
    bus.vert_sel  = '0;
    bus.a_rd_en   = 1'b0;
    bus.a_rd_addr = '0;
    bus.arr_clr   = 1'b0;
    bus.array_en  = 1'b0;
    bus.horz_zero = 1'b0;
    bus.res_valid = 1'b0;
    bus.res_idx   = '0;
    case (state_q)
      ST_LOAD_B: begin
        bus.busy      = 1'b1;
        bus.b_rd_en   = 1'b1;
        bus.b_rd_addr = IDXW'(k_cnt);
        if (k_cnt != '0) begin
          bus.vert_load = 1'b1;
          bus.vert_sel  = IDXW'(k_cnt - 1'b1);
        end
      end
      ST_PRIME: begin
        bus.busy      = 1'b1;
        bus.vert_load = 1'b1;
        bus.vert_sel  = IDXW'(M - 1);
        bus.arr_clr   = 1'b1;
        bus.a_rd_en   = 1'b1;
      end
      ST_RUN: begin
        bus.busy      = 1'b1;
        bus.array_en  = !stall;
        bus.horz_zero = (s_cnt >= M_S);
        if (s_plus1 < M_S1) begin
          bus.a_rd_en   = 1'b1;
          bus.a_rd_addr = IDXW'(s_plus1);
        end
        if (s_cnt >= LAT_S) begin
          bus.res_valid = 1'b1;
          bus.res_idx   = RESW'(s_cnt - LAT_S);
        end
      end
      ST_DONE: begin
        bus.done = 1'b1;
      end
      default: begin
        bus.busy = 1'b0;
      end
    endcase
  end

  assign bus.dbg_state = state_q;

endmodule
